// File: rtl/counter_timer_ctrl.sv
// Prescaled run/pause/abort controller that drives a plain up-counter as a timer.
// Optional sticky interrupt output: define COUNTER_TIMER_CTRL_STICKY_IRQ_EN.
module counter_timer_ctrl #(
    parameter int WORD_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      oneshot_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [WORD_WIDTH-1:0]     reload_i,
    input  logic                      will_overflow_i,
`ifdef COUNTER_TIMER_CTRL_STICKY_IRQ_EN
    input  logic                      irq_clr_i,
    output logic                      irq_o,
`endif
    output logic                      count_o,
    output logic                      load_o,
    output logic [WORD_WIDTH-1:0]     load_data_o,
    output logic                      busy_o,
    output logic                      expire_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [WORD_WIDTH-1:0]     r_q;
    logic                      oneshot_q;
    logic                      expire_q, expire_d;
    logic                      latch;
    logic                      tick;

    // A stop request suppresses any tick that would have fallen in the same cycle.
    assign tick = (state_q == RUN) && (presc_q == p_q) && !stop_i;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        count_o  = 1'b0;
        load_o   = 1'b0;
        expire_d = 1'b0;
        latch    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    latch   = 1'b1;
                    presc_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_o  = 1'b1;
                presc_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = PAUSE;
                end else begin
                    presc_d = (presc_q == p_q) ? '0
                                               : presc_q + PRESCALE_WIDTH'(1);
                    if (tick) begin
                        if (!will_overflow_i) begin
                            count_o = 1'b1;
                        end else begin
                            expire_d = 1'b1;
                            // One-shot lets the counter wrap to zero and stops.
                            if (oneshot_q) begin
                                count_o = 1'b1;
                                state_d = IDLE;
                            end else begin
                                load_o = 1'b1;
                            end
                        end
                    end
                end
            end
            PAUSE: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            p_q       <= '0;
            r_q       <= '0;
            oneshot_q <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            expire_q <= expire_d;
            if (latch) begin
                p_q       <= prescale_i;
                r_q       <= reload_i;
                oneshot_q <= oneshot_i;
            end
        end
    end

`ifdef COUNTER_TIMER_CTRL_STICKY_IRQ_EN
    logic irq_q;

    // Set takes priority so a clear racing a fresh expiry cannot lose it.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            irq_q <= 1'b0;
        end else if (expire_d) begin
            irq_q <= 1'b1;
        end else if (irq_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`endif

    assign busy_o      = (state_q != IDLE);
    assign expire_o    = expire_q;
    assign load_data_o = r_q;

endmodule
